// File: rtl/cache_line_mem_responder.sv
// Backing-memory responder for cache line refills and writebacks.
// Accepts one full-line request at a time, waits a fixed latency, then
// presents a response carrying the line address, data and an error flag.
module cache_line_mem_responder #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_BITS  = 32,
    parameter int MEM_LINES  = 256,
    parameter int LATENCY    = 4
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic                    ReqWrite,
    input  logic [ADDR_BITS-1:0]    ReqAddr,
    input  logic [LINE_BYTES*8-1:0] ReqData,
    output logic                    RspValid,
    input  logic                    RspReady,
    output logic                    RspWrite,
    output logic [ADDR_BITS-1:0]    RspAddr,
    output logic [LINE_BYTES*8-1:0] RspData,
    output logic                    RspErr
);
    localparam int LINE_BITS = LINE_BYTES * 8;
    localparam int OFFS_BITS = $clog2(LINE_BYTES);
    localparam int IDXF_W    = ADDR_BITS - OFFS_BITS;
    localparam int IDX_W     = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int CNT_W     = $clog2(LATENCY + 1);

    localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [IDXF_W-1:0]    LINES_LIM = IDXF_W'(MEM_LINES);
    localparam logic [ADDR_BITS-1:0] LINE_MASK = ~ADDR_BITS'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ready_q;

    // request payload held for the duration of the transaction
    logic                   wr_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [LINE_BITS-1:0]   data_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   inrange_q;

    // registered response
    logic                   rsp_valid_q;
    logic                   rsp_write_q;
    logic [ADDR_BITS-1:0]   rsp_addr_q;
    logic [LINE_BITS-1:0]   rsp_data_q;
    logic                   rsp_err_q;

    // backing storage, deliberately left unreset
    logic [LINE_BITS-1:0]   mem [MEM_LINES];

    logic [IDXF_W-1:0]      req_idx;
    logic                   req_inrange;
    logic                   accept;

    assign req_idx     = ReqAddr[ADDR_BITS-1:OFFS_BITS];
    assign req_inrange = (req_idx < LINES_LIM);
    // Rst_n gates the accept so a request seen on a reset edge neither
    // latches nor commits to storage.
    assign accept      = ReqValid && ready_q && Rst_n;

    // Writes commit on the accept edge; out-of-range lines are dropped.
    always_ff @(posedge Clk) begin
        if (accept && ReqWrite && req_inrange) begin
            mem[req_idx[IDX_W-1:0]] <= ReqData;
        end
    end

    // Latch the request payload on accept (data path, no reset needed).
    always_ff @(posedge Clk) begin
        if (accept) begin
            wr_q      <= ReqWrite;
            addr_q    <= ReqAddr & LINE_MASK;
            data_q    <= ReqData;
            idx_q     <= req_idx[IDX_W-1:0];
            inrange_q <= req_inrange;
        end
    end

    // Transaction FSM: IDLE accepts, WAIT counts latency, RESP holds until taken.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (ReqValid && ready_q) begin
                        ready_q <= 1'b0;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= wr_q;
                        rsp_addr_q  <= addr_q;
                        rsp_err_q   <= !inrange_q;
                        if (!inrange_q) begin
                            rsp_data_q <= '0;
                        end else if (wr_q) begin
                            rsp_data_q <= data_q;
                        end else begin
                            rsp_data_q <= mem[idx_q];
                        end
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // ready_q rises here so the next accept lands one cycle
                    // after the response handshake, never on the same edge.
                    if (RspReady) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ReqReady = ready_q;
    assign RspValid = rsp_valid_q;
    assign RspWrite = rsp_write_q;
    assign RspAddr  = rsp_addr_q;
    assign RspData  = rsp_data_q;
    assign RspErr   = rsp_err_q;

endmodule
